// File: rtl/ctrl_pipe.sv
// Control-path pipeline for a 5-stage MIPS-style core: ID/EX, EX/MEM, MEM/WB control registers,
// load-use / RAW hazard detection, branch flush and EX operand forwarding (macro CTRL_PIPE_FWD_EN).
module ctrl_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [10:0] id_ctrl,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        branch_taken,
    output logic        stall,
    output logic        if_flush,
    output logic        ex_alusrc,
    output logic [1:0]  ex_aluop,
    output logic        ex_regdst,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic        wb_regwrite,
    output logic        wb_memtoreg,
    output logic [4:0]  ex_dst,
    output logic [4:0]  mem_dst,
    output logic [4:0]  wb_dst,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b
);

    localparam int unsigned C_PCSRC    = 0;
    localparam int unsigned C_IFFLUSH  = 1;
    localparam int unsigned C_REGWRITE = 2;
    localparam int unsigned C_ALUSRC   = 3;
    localparam int unsigned C_ALUOP_LO = 4;
    localparam int unsigned C_REGDST   = 6;
    localparam int unsigned C_BRANCH   = 7;
    localparam int unsigned C_MEMWRITE = 8;
    localparam int unsigned C_MEMREAD  = 9;
    localparam int unsigned C_MEMTOREG = 10;

    // ID/EX
    logic       r_ex_valid;
    logic       r_ex_alusrc;
    logic [1:0] r_ex_aluop;
    logic       r_ex_regdst;
    logic       r_ex_memwrite;
    logic       r_ex_memread;
    logic       r_ex_regwrite;
    logic       r_ex_memtoreg;
    logic [4:0] r_ex_dst;
    logic [4:0] r_ex_rs;
    logic [4:0] r_ex_rt;
    // EX/MEM
    logic       r_mem_valid;
    logic       r_mem_memwrite;
    logic       r_mem_memread;
    logic       r_mem_regwrite;
    logic       r_mem_memtoreg;
    logic [4:0] r_mem_dst;
    // MEM/WB
    logic       r_wb_valid;
    logic       r_wb_regwrite;
    logic       r_wb_memtoreg;
    logic [4:0] r_wb_dst;

    logic       w_load_use;
    logic       w_raw;
    logic       w_stall;
    logic       w_issue;
    logic [4:0] w_id_dst;
    logic       w_unused_ctrl;

    // PCSrc and IF_Flush from the decoder are superseded by the locally resolved flush.
    assign w_unused_ctrl = id_ctrl[C_PCSRC] ^ id_ctrl[C_IFFLUSH];

    assign w_id_dst = id_ctrl[C_REGDST] ? id_rd : id_rt;

    assign w_load_use = id_valid && r_ex_valid && r_ex_memread && (r_ex_dst != '0)
                        && ((r_ex_dst == id_rs) || (r_ex_dst == id_rt));

`ifdef CTRL_PIPE_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (r_mem_valid && r_mem_regwrite && (r_mem_dst != '0) && (r_mem_dst == src))
            sel = 2'b10;
        else if (r_wb_valid && r_wb_regwrite && (r_wb_dst != '0) && (r_wb_dst == src))
            sel = 2'b01;
        return sel;
    endfunction

    assign w_raw = 1'b0;
    assign fwd_a = fwd_sel(r_ex_rs);
    assign fwd_b = fwd_sel(r_ex_rt);
`else
    // Without forwarding, any in-flight writer in EX or MEM must retire before ID may read.
    function automatic logic raw_hit(input logic [4:0] src);
        return (src != '0)
               && ((r_ex_valid && r_ex_regwrite && (r_ex_dst == src))
                || (r_mem_valid && r_mem_regwrite && (r_mem_dst == src)));
    endfunction

    logic w_unused_nofwd;
    assign w_unused_nofwd = ^{r_ex_rs, r_ex_rt, r_wb_valid};

    assign w_raw = id_valid && (raw_hit(id_rs) || raw_hit(id_rt));
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    // Gated by rst_n so the combinational outputs read 0 throughout reset.
    assign w_stall  = rst_n && (w_load_use || w_raw);
    assign stall    = w_stall;
    assign if_flush = rst_n && id_valid && id_ctrl[C_BRANCH] && branch_taken && !w_stall;
    assign w_issue  = id_valid && !w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_alusrc   <= 1'b0;
            r_ex_aluop    <= '0;
            r_ex_regdst   <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memtoreg <= 1'b0;
            r_ex_dst      <= '0;
            r_ex_rs       <= '0;
            r_ex_rt       <= '0;
        end else if (w_issue) begin
            r_ex_valid    <= 1'b1;
            r_ex_alusrc   <= id_ctrl[C_ALUSRC];
            r_ex_aluop    <= id_ctrl[C_ALUOP_LO +: 2];
            r_ex_regdst   <= id_ctrl[C_REGDST];
            r_ex_memwrite <= id_ctrl[C_MEMWRITE];
            r_ex_memread  <= id_ctrl[C_MEMREAD];
            r_ex_regwrite <= id_ctrl[C_REGWRITE];
            r_ex_memtoreg <= id_ctrl[C_MEMTOREG];
            r_ex_dst      <= w_id_dst;
            r_ex_rs       <= id_rs;
            r_ex_rt       <= id_rt;
        end else begin
            r_ex_valid    <= 1'b0;
            r_ex_alusrc   <= 1'b0;
            r_ex_aluop    <= '0;
            r_ex_regdst   <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memtoreg <= 1'b0;
            r_ex_dst      <= '0;
            r_ex_rs       <= '0;
            r_ex_rt       <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid    <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_dst      <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_dst       <= '0;
        end else begin
            r_mem_valid    <= r_ex_valid;
            r_mem_memwrite <= r_ex_memwrite;
            r_mem_memread  <= r_ex_memread;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memtoreg <= r_ex_memtoreg;
            r_mem_dst      <= r_ex_dst;
            r_wb_valid     <= r_mem_valid;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_memtoreg  <= r_mem_memtoreg;
            r_wb_dst       <= r_mem_dst;
        end
    end

    assign ex_alusrc    = r_ex_alusrc;
    assign ex_aluop     = r_ex_aluop;
    assign ex_regdst    = r_ex_regdst;
    assign ex_dst       = r_ex_dst;
    assign mem_memwrite = r_mem_memwrite;
    assign mem_memread  = r_mem_memread;
    assign mem_dst      = r_mem_dst;
    assign wb_regwrite  = r_wb_regwrite;
    assign wb_memtoreg  = r_wb_memtoreg;
    assign wb_dst       = r_wb_dst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe; expectations cover both builds (CTRL_PIPE_FWD_EN defined or not).
module tb_ctrl_pipe;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [10:0] id_ctrl;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        branch_taken;
    logic        stall;
    logic        if_flush;
    logic        ex_alusrc;
    logic [1:0]  ex_aluop;
    logic        ex_regdst;
    logic        mem_memwrite;
    logic        mem_memread;
    logic        wb_regwrite;
    logic        wb_memtoreg;
    logic [4:0]  ex_dst;
    logic [4:0]  mem_dst;
    logic [4:0]  wb_dst;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [28:0] outs;

    // Decoder bundles: lw, R-type add/sub, beq (PCSrc/IF_Flush bits set), sw.
    localparam logic [10:0] LW  = 11'h60C;
    localparam logic [10:0] ADD = 11'h064;
    localparam logic [10:0] BEQ = 11'h093;
    localparam logic [10:0] SW  = 11'h108;

`ifdef CTRL_PIPE_FWD_EN
    localparam int unsigned LU_CYC = 1;
`else
    localparam int unsigned LU_CYC = 2;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_st;

    ctrl_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_ctrl      (id_ctrl),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .branch_taken (branch_taken),
        .stall        (stall),
        .if_flush     (if_flush),
        .ex_alusrc    (ex_alusrc),
        .ex_aluop     (ex_aluop),
        .ex_regdst    (ex_regdst),
        .mem_memwrite (mem_memwrite),
        .mem_memread  (mem_memread),
        .wb_regwrite  (wb_regwrite),
        .wb_memtoreg  (wb_memtoreg),
        .ex_dst       (ex_dst),
        .mem_dst      (mem_dst),
        .wb_dst       (wb_dst),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    assign outs = {stall, if_flush, ex_alusrc, ex_aluop, ex_regdst, mem_memwrite, mem_memread,
                   wb_regwrite, wb_memtoreg, ex_dst, mem_dst, wb_dst, fwd_a, fwd_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [10:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic tk);
        id_valid     = v;
        id_ctrl      = c;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        branch_taken = tk;
    endtask

    task automatic idle();
        drive(1'b0, 11'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a taken branch presented: every output must read 0.
        rst_n = 1'b0;
        drive(1'b1, BEQ, 5'd1, 5'd2, 5'd0, 1'b1);
        #1 check("rst_outs", 32'(outs), 0);
        tick();
        rst_n = 1'b1;
        idle();
        #1 check("post_rst_outs", 32'(outs), 0);

        // lw $2 ; add $3,$2,$4
        tick(); drive(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0);
        #1 check("lu_first_nostall", 32'(stall), 0);
        tick(); drive(1'b1, ADD, 5'd2, 5'd4, 5'd3, 1'b0);
        #1 check("lu_stall", 32'(stall), 1);
        check("lu_ex_dst", 32'(ex_dst), 2);
        check("lu_ex_alusrc", 32'(ex_alusrc), 1);
        tick();
        #1 check("lu_bubble_alusrc", 32'(ex_alusrc), 0);
        check("lu_bubble_dst", 32'(ex_dst), 0);
        check("lu_mem_memread", 32'(mem_memread), 1);
        check("lu_mem_dst", 32'(mem_dst), 2);
`ifdef CTRL_PIPE_FWD_EN
        check("lu_release", 32'(stall), 0);
`else
        check("lu_raw_stall2", 32'(stall), 1);
        tick();
        #1 check("lu_release", 32'(stall), 0);
        check("lu_wb_dst", 32'(wb_dst), 2);
`endif
        tick(); idle();
        #1 check("lu_add_ex_dst", 32'(ex_dst), 3);
        check("lu_add_regdst", 32'(ex_regdst), 1);
        check("lu_add_aluop", 32'(ex_aluop), 2);
`ifdef CTRL_PIPE_FWD_EN
        check("lu_wb_memtoreg", 32'(wb_memtoreg), 1);
        check("lu_fwd_a_wb", 32'(fwd_a), 1);
`else
        check("lu_fwd_a_off", 32'(fwd_a), 0);
`endif
        check("lu_fwd_b", 32'(fwd_b), 0);
        drain();

        // add $5,$1,$1 ; sub $6,$5,$5 back to back
        tick(); drive(1'b1, ADD, 5'd1, 5'd1, 5'd5, 1'b0);
        #1 check("raw_first_nostall", 32'(stall), 0);
        tick(); drive(1'b1, ADD, 5'd5, 5'd5, 5'd6, 1'b0);
`ifdef CTRL_PIPE_FWD_EN
        #1 check("raw_nostall_fwd", 32'(stall), 0);
`else
        #1 check("raw_ex_stall", 32'(stall), 1);
        tick();
        #1 check("raw_mem_stall", 32'(stall), 1);
        tick();
        #1 check("raw_release", 32'(stall), 0);
`endif
        tick(); idle();
        #1 check("raw_sub_ex_dst", 32'(ex_dst), 6);
`ifdef CTRL_PIPE_FWD_EN
        check("fwd_a_mem", 32'(fwd_a), 2);
        check("fwd_b_mem", 32'(fwd_b), 2);
`else
        check("fwd_a_off", 32'(fwd_a), 0);
        check("fwd_b_off", 32'(fwd_b), 0);
`endif
        drain();

        // Same pair with an unrelated add $7,$8,$9 between them
        tick(); drive(1'b1, ADD, 5'd1, 5'd1, 5'd5, 1'b0);
        tick(); drive(1'b1, ADD, 5'd8, 5'd9, 5'd7, 1'b0);
        #1 check("gap_mid_nostall", 32'(stall), 0);
        tick(); drive(1'b1, ADD, 5'd5, 5'd5, 5'd6, 1'b0);
`ifdef CTRL_PIPE_FWD_EN
        #1 check("gap_nostall", 32'(stall), 0);
        tick(); idle();
        #1 check("fwd_a_wb", 32'(fwd_a), 1);
        check("fwd_b_wb", 32'(fwd_b), 1);
`else
        #1 check("gap_mem_stall", 32'(stall), 1);
        tick();
        #1 check("gap_release", 32'(stall), 0);
        tick(); idle();
        #1 check("gap_fwd_a_off", 32'(fwd_a), 0);
`endif
        check("gap_sub_ex_dst", 32'(ex_dst), 6);
        drain();

        // Taken beq, no hazard; flush follows branch_taken combinationally
        tick(); drive(1'b1, BEQ, 5'd10, 5'd11, 5'd0, 1'b1);
        #1 check("br_flush", 32'(if_flush), 1);
        check("br_nostall", 32'(stall), 0);
        branch_taken = 1'b0;
        #1 check("br_not_taken", 32'(if_flush), 0);
        tick(); idle();
        #1 check("br_flush_once", 32'(if_flush), 0);
        check("br_ex_aluop", 32'(ex_aluop), 1);
        check("br_ex_dst", 32'(ex_dst), 11);
        drain();

        // lw $2 ; beq $2,$3 taken: flush only on release
        tick(); drive(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0);
        tick(); drive(1'b1, BEQ, 5'd2, 5'd3, 5'd0, 1'b1);
        #1 check("brlu_stall", 32'(stall), 1);
        check("brlu_held_noflush", 32'(if_flush), 0);
        tick();
`ifndef CTRL_PIPE_FWD_EN
        #1 check("brlu_raw_stall", 32'(stall), 1);
        check("brlu_raw_noflush", 32'(if_flush), 0);
        tick();
`endif
        #1 check("brlu_release_nostall", 32'(stall), 0);
        check("brlu_release_flush", 32'(if_flush), 1);
        tick(); idle();
        #1 check("brlu_flush_once", 32'(if_flush), 0);
        drain();

        // Writer of $0 then reader of $0
        tick(); drive(1'b1, LW, 5'd1, 5'd0, 5'd0, 1'b0);
        tick(); drive(1'b1, ADD, 5'd0, 5'd0, 5'd4, 1'b0);
        #1 check("zero_nostall", 32'(stall), 0);
        tick(); drive(1'b0, LW, 5'd1, 5'd2, 5'd0, 1'b0);
        #1 check("zero_fwd_a", 32'(fwd_a), 0);
        check("zero_fwd_b", 32'(fwd_b), 0);
        check("zero_ex_dst", 32'(ex_dst), 4);
        check("zero_mem_dst", 32'(mem_dst), 0);
        // Invalid ID instruction (carrying lw bits) must enter EX as a bubble
        tick(); idle();
        #1 check("invalid_bubble_alusrc", 32'(ex_alusrc), 0);
        check("invalid_bubble_dst", 32'(ex_dst), 0);
        drain();

        // sw flows through MEM with MemWrite, never writes back
        tick(); drive(1'b1, SW, 5'd1, 5'd2, 5'd0, 1'b0);
        tick(); idle();
        #1 check("sw_ex_alusrc", 32'(ex_alusrc), 1);
        tick();
        #1 check("sw_mem_memwrite", 32'(mem_memwrite), 1);
        check("sw_mem_memread", 32'(mem_memread), 0);
        tick();
        #1 check("sw_wb_regwrite", 32'(wb_regwrite), 0);
        check("sw_mem_after", 32'(mem_memwrite), 0);
        drain();

        // Reset pulsed mid-stall, then a fresh lw/add pair
        tick(); drive(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0);
        tick(); drive(1'b1, ADD, 5'd2, 5'd4, 5'd3, 1'b0);
        #1 check("rst_pre_stall", 32'(stall), 1);
        rst_n = 1'b0;
        #1 check("rst_mid_stall_outs", 32'(outs), 0);
        tick();
        #1 check("rst_held_outs", 32'(outs), 0);
        rst_n = 1'b1;
        idle();
        #1 check("rst_release_empty", 32'(outs), 0);
        tick(); drive(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0);
        #1 check("rst_lw_nostall", 32'(stall), 0);
        tick(); drive(1'b1, ADD, 5'd2, 5'd4, 5'd3, 1'b0);
        #1;
        n_st = 0;
        while (stall && n_st < 8) begin
            n_st++;
            tick();
            #1;
        end
        check("rst_lu_stall_cycles", n_st, LU_CYC);
        tick(); idle();
        #1 check("rst_add_ex_dst", 32'(ex_dst), 3);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
